dmem_responder: RTL and testbench

- Data-side memory responder for the single-cycle RV32 core. It answers the core's store/load interface: write strobe, funct3-coded size, ALU-computed address, store data and load data.
- Contains a byte-addressable RAM and a small MMIO window. The window holds a free-running cycle counter, a console TX FIFO with a valid/ready drain port, and a sticky fault register.
- Reads are combinational, as a single-cycle core requires. Writes commit on the rising clock edge.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_responder_sync_fifo.sv | 74 +++++++
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_responder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared encodings for the data-side memory responder:
//               funct3 access sizes, MMIO register offsets, fault bit indices.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // funct3 access-size coding used by loads and stores
  typedef enum logic [2:0] {
    MS_B  = 3'b000,
    MS_H  = 3'b001,
    MS_W  = 3'b010,
    MS_BU = 3'b100,
    MS_HU = 3'b101
  } memsize_e;

  // Register offsets inside the 16-byte MMIO window
  localparam logic [3:0] OFF_CYCLE   = 4'h0;
  localparam logic [3:0] OFF_CONSOLE = 4'h4;
  localparam logic [3:0] OFF_FAULT   = 4'h8;

  // Sticky fault register bit positions
  localparam int FB_MISALIGN = 0;
  localparam int FB_UNMAPPED = 1;
  localparam int FB_BADSIZE  = 2;
  localparam int FB_OVERFLOW = 3;
  localparam int FAULT_W     = 4;

  // funct3 values that do not name any load/store size
  function automatic logic is_bad_size(input logic [2:0] s);
    return (s == 3'b011) || (s == 3'b110) || (s == 3'b111);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count. A push while full is
//               accepted only when a pop happens in the same cycle. The head
//               output reads zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

  // A full FIFO can still take a push when the head leaves the same cycle
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_i);

  // Next-state pointers and occupancy
  always_comb begin
    wr_d    = push_ok ? wr_q + PW'(1) : wr_q;
    rd_d    = pop_ok  ? rd_q + PW'(1) : rd_q;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared by reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless while the pointers say empty
  always_ff @(posedge clk_i) begin
    if (push_ok && !reset_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data memory for a single-cycle RV32 core: byte-addressable
//               RAM plus an MMIO window with cycle counter, console TX FIFO
//               and sticky fault register. Loads are combinational, stores
//               commit on the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [2:0]  memsize,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        fault,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0]        ram_q [DEPTH_WORDS];
  logic [31:0]        cycle_q, cycle_d;
  logic [FAULT_W-1:0] fault_q, fault_d, fault_new;

  logic        ram_hit, mmio_hit, unmapped, bad_size, misaligned, access_ok;
  logic        con_size_err, st_ok, ram_we, con_push, con_ovf, fault_clr;
  logic        con_full, con_empty;
  logic [CW-1:0] con_count;
  logic [31:0] cnt32;
  logic [2:0]  cnt_sat;
  logic [AW-1:0] word_idx;
  logic [3:0]  byte_en;
  logic [31:0] wr_lanes, mmio_word, src_word;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // ---------------- decode and access validity ----------------
  assign ram_hit    = (addr < RAM_BYTES);
  assign mmio_hit   = (addr[31:4] == MMIO_BASE[31:4]);
  assign unmapped   = !ram_hit && !mmio_hit;
  assign bad_size   = is_bad_size(memsize);
  assign misaligned = !bad_size &&
                      (((memsize == MS_H || memsize == MS_HU) && addr[0]) ||
                       ((memsize == MS_W) && (addr[1:0] != 2'b00)));
  assign access_ok  = !bad_size && !misaligned && !unmapped;
  assign word_idx   = addr[AW+1:2];

  // The console only takes bytes; wider stores there count as misaligned
  assign con_size_err = memwrite && mmio_hit && (addr[3:2] == 2'b01) &&
                        (memsize == MS_H || memsize == MS_HU || memsize == MS_W);
  assign st_ok     = memwrite && access_ok && !con_size_err;
  assign ram_we    = st_ok && ram_hit && !reset;
  assign con_push  = st_ok && mmio_hit && (addr[3:0] == OFF_CONSOLE) &&
                     (memsize == MS_B || memsize == MS_BU);
  assign fault_clr = st_ok && mmio_hit && (addr[3:0] == OFF_FAULT) && (memsize == MS_W);
  // Full implies non-empty, so a ready consumer always frees a slot
  assign con_ovf   = con_push && con_full && !con_ready;

  // ---------------- RAM store path ----------------
  // Byte enables and lane-replicated write data from size and address
  always_comb begin
    byte_en  = 4'b0000;
    wr_lanes = writedata;
    case (memsize)
      MS_B, MS_BU: begin
        byte_en  = 4'b0001 << addr[1:0];
        wr_lanes = {4{writedata[7:0]}};
      end
      MS_H, MS_HU: begin
        byte_en  = addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{writedata[15:0]}};
      end
      MS_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // RAM write with per-lane enables; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) ram_q[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  // ---------------- MMIO registers ----------------
  assign cycle_d   = cycle_q + 32'd1;
  assign fault_new = {con_ovf, bad_size, unmapped, misaligned | con_size_err};
  // Set wins over a same-cycle clear
  assign fault_d   = (fault_clr ? '0 : fault_q) | fault_new;
  assign fault     = |fault_q;

  // Free-running cycle counter and sticky fault bits
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      fault_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      fault_q <= fault_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (con_push),
    .pop_i   (con_ready),
    .wdata_i (writedata[7:0]),
    .rdata_o (con_data),
    .full_o  (con_full),
    .empty_o (con_empty),
    .count_o (con_count)
  );

  assign con_valid = !con_empty;
  assign cnt32     = 32'(con_count);
  assign cnt_sat   = (cnt32 > 32'd7) ? 3'd7 : cnt32[2:0];

  // ---------------- load path ----------------
  // MMIO register selected by word offset
  always_comb begin
    mmio_word = '0;
    case (addr[3:2])
      2'b00:   mmio_word = cycle_q;
      2'b01:   mmio_word = {27'b0, cnt_sat, con_empty, con_full};
      2'b10:   mmio_word = {28'b0, fault_q};
      default: mmio_word = '0;
    endcase
  end

  assign src_word = ram_hit ? ram_q[word_idx] : (mmio_hit ? mmio_word : '0);
  assign lane_b   = src_word[8*addr[1:0] +: 8];
  assign lane_h   = addr[1] ? src_word[31:16] : src_word[15:0];

  // Lane extraction and extension; faulting loads read zero
  always_comb begin
    readdata = '0;
    if (access_ok) begin
      case (memsize)
        MS_B:    readdata = {{24{lane_b[7]}}, lane_b};
        MS_BU:   readdata = {24'b0, lane_b};
        MS_H:    readdata = {{16{lane_h[15]}}, lane_h};
        MS_HU:   readdata = {16'b0, lane_h};
        MS_W:    readdata = src_word;
        default: readdata = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder. A byte-level reference
//               model predicts outputs for every driven cycle; a monitor
//               compares DUT outputs against the queued predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int          DEPTH_WORDS = 1024;
  localparam int          FIFO_DEPTH  = 4;
  localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;
  localparam logic [31:0] RAM_BYTES   = 32'(DEPTH_WORDS * 4);

  logic        clk = 1'b0;
  logic        reset, memwrite, con_ready;
  logic [2:0]  memsize;
  logic [31:0] addr, writedata, readdata;
  logic        fault, con_valid;
  logic [7:0]  con_data;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .MMIO_BASE   (MMIO_BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .memsize   (memsize),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .fault     (fault),
    .con_valid (con_valid),
    .con_data  (con_data),
    .con_ready (con_ready)
  );

  typedef struct {
    bit          chk_rd;
    logic [31:0] rd;
    bit          flt;
    bit          cv;
    logic [7:0]  cd;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   r_rdy  = 1'b0;

  // Reference model state: byte memory, FIFO contents, fault bits, cycle
  logic [7:0]  m_ram [int];
  logic [7:0]  m_fifo[$];
  logic [3:0]  m_fault;
  logic [31:0] m_cycle;
  bit          m_known = 1'b0;

  function automatic int nbytes(input logic [2:0] s);
    if (s == MS_B || s == MS_BU) return 1;
    if (s == MS_H || s == MS_HU) return 2;
    if (s == MS_W) return 4;
    return 0;
  endfunction

  // bit0 misaligned, bit1 unmapped, bit2 bad size
  function automatic logic [3:0] acc_faults(input logic [2:0] s, input logic [31:0] a);
    logic [3:0] f;
    f = 4'b0;
    if (s == 3'b011 || s == 3'b110 || s == 3'b111) f[2] = 1'b1;
    else if ((nbytes(s) == 2 && a[0]) || (nbytes(s) == 4 && a[1:0] != 2'b00)) f[0] = 1'b1;
    if (!(a < RAM_BYTES) && a[31:4] != MMIO_BASE[31:4]) f[1] = 1'b1;
    return f;
  endfunction

  function automatic logic [31:0] m_mmio(input logic [3:0] off);
    int n;
    n = m_fifo.size();
    case (off[3:2])
      2'd0: return m_cycle;
      2'd1: return {27'b0, 3'((n > 7) ? 7 : n), n == 0, n == FIFO_DEPTH};
      2'd2: return {28'b0, m_fault};
      default: return 32'h0;
    endcase
  endfunction

  // Returns 0 when the load touches RAM bytes never written
  function automatic bit m_load(input logic [2:0] s, input logic [31:0] a,
                                output logic [31:0] v);
    logic [31:0] raw, w;
    int n;
    v = 32'h0;
    if (acc_faults(s, a) != 4'b0) return 1'b1;
    n   = nbytes(s);
    raw = 32'h0;
    if (a < RAM_BYTES) begin
      for (int i = 0; i < n; i++) begin
        if (!m_ram.exists(int'(a) + i)) return 1'b0;
        raw = raw | (32'(m_ram[int'(a) + i]) << (8 * i));
      end
    end else begin
      w   = m_mmio(a[3:0]);
      raw = w >> (8 * int'(a[1:0]));
      if (n < 4) raw = raw & ((32'h1 << (8 * n)) - 32'h1);
    end
    if (s == MS_B)      v = {{24{raw[7]}}, raw[7:0]};
    else if (s == MS_H) v = {{16{raw[15]}}, raw[15:0]};
    else                v = raw;
    return 1'b1;
  endfunction

  // One clock of stimulus: drive, predict outputs, then advance the model
  task automatic step(input bit rst, input bit we, input logic [2:0] s,
                      input logic [31:0] a, input logic [31:0] wd, input string tag,
                      input bit use_k = 1'b0, input logic [31:0] k = 32'h0);
    exp_t e;
    logic [31:0] v;
    logic [3:0]  f;
    bit known, pop, push, ovf, clr, mmio;
    int pre;
    @(negedge clk);
    reset = rst; memwrite = we; memsize = s; addr = a; writedata = wd; con_ready = r_rdy;
    known = m_load(s, a, v);
    if (m_known) begin
      e.chk_rd = known || use_k;
      e.rd     = use_k ? k : v;
      e.flt    = (m_fault != 4'b0);
      e.cv     = (m_fifo.size() > 0);
      e.cd     = e.cv ? m_fifo[0] : 8'h00;
      e.tag    = tag;
      exp_q.push_back(e);
    end
    if (rst) begin
      m_fifo.delete();
      m_fault = 4'b0;
      m_cycle = 32'h0;
      m_known = 1'b1;
    end else begin
      f    = acc_faults(s, a);
      mmio = (a[31:4] == MMIO_BASE[31:4]);
      if (we && mmio && a[3:2] == 2'd1 && nbytes(s) >= 2) f[0] = 1'b1;
      clr = 1'b0; push = 1'b0; ovf = 1'b0;
      if (we && f == 4'b0) begin
        if (a < RAM_BYTES) begin
          for (int i = 0; i < nbytes(s); i++) m_ram[int'(a) + i] = wd[8*i +: 8];
        end else if (a[3:0] == 4'h4 && nbytes(s) == 1) push = 1'b1;
        else if (a[3:0] == 4'h8 && s == MS_W) clr = 1'b1;
      end
      pre = m_fifo.size();
      pop = (pre > 0) && r_rdy;
      if (pop) void'(m_fifo.pop_front());
      if (push) begin
        if (pre < FIFO_DEPTH || pop) m_fifo.push_back(wd[7:0]);
        else ovf = 1'b1;
      end
      m_fault = (clr ? 4'b0 : m_fault) | f | {ovf, 3'b000};
      m_cycle = m_cycle + 32'd1;
    end
  endtask

  task automatic ld(input logic [2:0] s, input logic [31:0] a, input string tag);
    step(1'b0, 1'b0, s, a, 32'h0, tag);
  endtask
  task automatic ldk(input logic [2:0] s, input logic [31:0] a, input logic [31:0] k,
                     input string tag);
    step(1'b0, 1'b0, s, a, 32'h0, tag, 1'b1, k);
  endtask
  task automatic st(input logic [2:0] s, input logic [31:0] a, input logic [31:0] wd,
                    input string tag);
    step(1'b0, 1'b1, s, a, wd, tag);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, MS_W, 32'h0, 32'h0, "idle");
  endtask

  task automatic chk(input string name, input string tag, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s [%s]: got %h want %h", name, tag, act, want);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest prediction each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_rd) chk("readdata", e.tag, readdata, e.rd);
        chk("fault", e.tag, 32'(fault), 32'(e.flt));
        chk("con_valid", e.tag, 32'(con_valid), 32'(e.cv));
        chk("con_data", e.tag, 32'(con_data), 32'(e.cd));
      end
    end
  end

  initial begin
    logic [2:0]  s;
    logic [31:0] a;
    int          r;
    reset = 1'b1; memwrite = 1'b0; memsize = MS_W; addr = 32'h0;
    writedata = 32'h0; con_ready = 1'b0;

    step(1'b1, 1'b0, MS_W, 32'h0, 32'h0, "reset");
    step(1'b1, 1'b0, MS_W, 32'h0, 32'h0, "reset");
    ldk(MS_W, MMIO_BASE + 32'h4, 32'h0000_0002, "console_after_reset");

    for (int w = 0; w < 16; w++) st(MS_W, 32'(w * 4), $urandom, "init");

    // Byte-lane write/read
    st(MS_W, 32'h10, 32'h1122_3344, "sw10");
    st(MS_B, 32'h13, 32'h0000_00AA, "sb13");
    ldk(MS_W,  32'h10, 32'hAA22_3344, "lw10");
    ldk(MS_B,  32'h13, 32'hFFFF_FFAA, "lb13");
    ldk(MS_BU, 32'h13, 32'h0000_00AA, "lbu13");
    ldk(MS_H,  32'h12, 32'hFFFF_AA22, "lh12");
    ldk(MS_HU, 32'h12, 32'h0000_AA22, "lhu12");

    // Faults
    st(MS_W, 32'h12, 32'hDEAD_BEEF, "sw_misaligned");
    ldk(MS_W, 32'h10, 32'hAA22_3344, "ram_unchanged");
    ldk(MS_W, MMIO_BASE + 32'h8, 32'h1, "fault_misal");
    ldk(MS_W, 32'h0010_0000, 32'h0, "lw_unmapped");
    ldk(MS_W, MMIO_BASE + 32'h8, 32'h3, "fault_unmapped");
    ldk(3'b011, 32'h0, 32'h0, "bad_size");
    ldk(MS_W, MMIO_BASE + 32'h8, 32'h7, "fault_badsize");
    st(MS_W, MMIO_BASE + 32'h8, 32'h0, "fault_clear");
    ldk(MS_W, MMIO_BASE + 32'h8, 32'h0, "fault_cleared");

    // FIFO fill with overflow
    r_rdy = 1'b0;
    for (int i = 0; i < 5; i++) st(MS_B, MMIO_BASE + 32'h4, 32'(8'h41 + i), "con_push");
    ldk(MS_W, MMIO_BASE + 32'h4, 32'h0000_0011, "console_full");
    ldk(MS_W, MMIO_BASE + 32'h8, 32'h8, "fault_overflow");
    ldk(MS_B, MMIO_BASE + 32'h4, 32'h0000_0011, "console_lb");
    st(MS_H, MMIO_BASE + 32'h4, 32'h0000_0050, "con_sh");
    ldk(MS_W, MMIO_BASE + 32'h8, 32'h9, "fault_con_sh");
    st(MS_W, MMIO_BASE + 32'h8, 32'h0, "fault_clear2");

    // Push and pop together while full
    r_rdy = 1'b1;
    st(MS_B, MMIO_BASE + 32'h4, 32'h46, "con_pushpop_full");
    r_rdy = 1'b0;
    ldk(MS_W, MMIO_BASE + 32'h4, 32'h0000_0011, "console_still_full");
    ldk(MS_W, MMIO_BASE + 32'h8, 32'h0, "no_overflow");

    // Drain
    r_rdy = 1'b1;
    idle(5);
    ldk(MS_W, MMIO_BASE + 32'h4, 32'h0000_0002, "console_drained");
    r_rdy = 1'b0;

    // Cycle counter
    step(1'b1, 1'b0, MS_W, 32'h0, 32'h0, "reset_cycle");
    idle(10);
    ldk(MS_W, MMIO_BASE, 32'd10, "cycle10");
    ldk(MS_H, MMIO_BASE, 32'd11, "cycle_lh");
    st(MS_W, MMIO_BASE, 32'h1234_5678, "cycle_store_ignored");
    ldk(MS_W, MMIO_BASE, 32'd13, "cycle13");

    // Reset mid-operation with a same-cycle console push
    for (int i = 0; i < 3; i++) st(MS_B, MMIO_BASE + 32'h4, 32'(8'h61 + i), "con_q3");
    ld(3'b111, 32'h0, "bad_size_pre_reset");
    step(1'b1, 1'b1, MS_B, MMIO_BASE + 32'h4, 32'h55, "reset_midop");
    ldk(MS_W, MMIO_BASE, 32'h0, "cycle_after_reset");
    ldk(MS_W, MMIO_BASE + 32'h4, 32'h0000_0002, "console_after_midop");
    ldk(MS_W, MMIO_BASE + 32'h8, 32'h0, "fault_after_midop");
    ldk(MS_W, 32'h10, 32'hAA22_3344, "ram_retained");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      a = $urandom_range(0, 63);
      else if (r < 9) a = MMIO_BASE | 32'($urandom_range(0, 15));
      else            a = 32'h0010_0000 + 32'($urandom_range(0, 255));
      case ($urandom_range(0, 11))
        0, 1, 2: s = MS_B;
        3, 4:    s = MS_H;
        5, 6, 7: s = MS_W;
        8:       s = MS_BU;
        9:       s = MS_HU;
        default: s = 3'($urandom_range(0, 7));
      endcase
      r_rdy = ($urandom_range(0, 1) == 1);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), s, a, $urandom, "random");
    end
    idle(1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
